// File: rtl/jogo_sequencia_param.sv
// Sequence-memory game core: position counter, switch register, sequence ROM,
// comparator and control FSM with move-edge detection and early exit on mismatch.
module jogo_sequencia_param #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic [WIDTH-1:0]  chaves,
  output logic              pronto,
  output logic              acertou,
  output logic              errou,
  output logic              db_igual,
  output logic              db_iniciar,
  output logic              db_jogada,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [WIDTH-1:0]  db_memoria,
  output logic [WIDTH-1:0]  db_chaves,
  output logic [3:0]        db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PREPARA    = 4'd1,
    ESPERA     = 4'd2,
    REGISTRA   = 4'd4,
    COMPARA    = 4'd5,
    PROXIMO    = 4'd6,
    FIM_ACERTO = 4'd10,
    FIM_ERRO   = 4'd14
  } estado_t;

  localparam logic [ADDR_W-1:0] ULTIMA = ADDR_W'(DEPTH - 1);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] contagem_q, contagem_d;
  logic [WIDTH-1:0]  chaves_q, chaves_d;
  logic              jogada_prev_q;

  logic              pulso;
  logic              zera_c, conta_c, zera_r, registra_r;
  logic [WIDTH-1:0]  mem_rd;
  logic              igual;

  // Sequence word i is (5*i + 3) truncated to WIDTH bits.
  function automatic logic [WIDTH-1:0] rom_word(input int unsigned i);
    return WIDTH'(32'd5 * i + 32'd3);
  endfunction

  // Combinational ROM read at the current position.
  always_comb begin
    mem_rd = rom_word(0);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (contagem_q == ADDR_W'(i)) mem_rd = rom_word(i);
    end
  end

  assign pulso = jogada & ~jogada_prev_q;
  assign igual = (chaves_q == mem_rd);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q      <= INICIAL;
      contagem_q    <= '0;
      chaves_q      <= '0;
      jogada_prev_q <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      contagem_q    <= contagem_d;
      chaves_q      <= chaves_d;
      jogada_prev_q <= jogada;
    end
  end

  // Counter saturates at the last position; register captures the player value.
  always_comb begin
    contagem_d = contagem_q;
    chaves_d   = chaves_q;
    if (zera_c) begin
      contagem_d = '0;
    end else if (conta_c && (contagem_q != ULTIMA)) begin
      contagem_d = contagem_q + ADDR_W'(1);
    end
    if (zera_r) begin
      chaves_d = '0;
    end else if (registra_r) begin
      chaves_d = chaves;
    end
  end

  // Control FSM: next state and strobes.
  always_comb begin
    estado_d   = estado_q;
    zera_c     = 1'b0;
    conta_c    = 1'b0;
    zera_r     = 1'b0;
    registra_r = 1'b0;
    case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = PREPARA;
      end
      PREPARA: begin
        zera_c   = 1'b1;
        zera_r   = 1'b1;
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (pulso) estado_d = REGISTRA;
      end
      REGISTRA: begin
        registra_r = 1'b1;
        estado_d   = COMPARA;
      end
      COMPARA: begin
        if (!igual)                    estado_d = FIM_ERRO;
        else if (contagem_q == ULTIMA) estado_d = FIM_ACERTO;
        else                           estado_d = PROXIMO;
      end
      PROXIMO: begin
        conta_c  = 1'b1;
        estado_d = ESPERA;
      end
      FIM_ACERTO: begin
        if (iniciar) estado_d = PREPARA;
      end
      FIM_ERRO: begin
        if (iniciar) estado_d = PREPARA;
      end
      default: estado_d = INICIAL;
    endcase
  end

  // Moore result flags decoded straight from the state register.
  assign pronto      = (estado_q == FIM_ACERTO) || (estado_q == FIM_ERRO);
  assign acertou     = (estado_q == FIM_ACERTO);
  assign errou       = (estado_q == FIM_ERRO);

  assign db_igual    = igual;
  assign db_iniciar  = iniciar;
  assign db_jogada   = pulso;
  assign db_contagem = contagem_q;
  assign db_memoria  = mem_rd;
  assign db_chaves   = chaves_q;
  assign db_estado   = estado_q;

endmodule

// File: doc/jogo_sequencia_param.md
Name: jogo_sequencia_param

Overview:
- Parametrised successor to the fixed 4-bit, 16-position switch/memory comparison circuit.
- Merges datapath and control into one block: position counter, switch register, internal sequence ROM, comparator and FSM.
- Adds player-move edge detection, early exit on the first mismatch, and separate hit/miss results.
- Sits under the board top level. Debug outputs are raw binary; the top level drives hexa7seg decoders from them.

Parameters:
- WIDTH, 4: bits per sequence word and per switch input.
- DEPTH, 16: number of positions in the sequence (minimum 2).
- ADDR_W, 4: counter width; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; returns everything to initial values.
- iniciar  in  1  level; starts or restarts a round.
- jogada  in  1  player-move strobe; only its rising edge counts.
- chaves  in  WIDTH  player value.
- pronto  out  1  round finished.
- acertou  out  1  whole sequence matched.
- errou  out  1  mismatch found.
- db_igual  out  1  combinational: registered chaves == mem[contagem].
- db_iniciar  out  1  copy of iniciar.
- db_jogada  out  1  internal one-cycle move pulse.
- db_contagem  out  ADDR_W  current position.
- db_memoria  out  WIDTH  mem[contagem].
- db_chaves  out  WIDTH  registered chaves.
- db_estado  out  4  state code.

Behaviour:
- ROM: read-only, combinational read. mem[i] = (5*i + 3) mod 2**WIDTH for i in 0..DEPTH-1. WIDTH=4 gives 3, 8, 13, 2, 7, 12, 1, 6, ...
- Edge detector:
  - jogada_d is a flop, reset value 0.
  - pulse = jogada & ~jogada_d.
  - Holding jogada high yields exactly one pulse.
  - A pulse in any state other than ESPERA is discarded; it is neither queued nor counted.
- Counter: zeroed synchronously by zeraC; +1 on contaC; never exceeds DEPTH-1.
- Register: zeroed by zeraR; loads chaves on registraR.
- FSM, state code in brackets:
  - INICIAL [0]: no control strobes asserted. iniciar=1 -> PREPARA.
  - PREPARA [1]: zeraC=1, zeraR=1. -> ESPERA.
  - ESPERA [2]: pulse -> REGISTRA; otherwise stay.
  - REGISTRA [4]: registraR=1. -> COMPARA.
  - COMPARA [5]: if db_igual=0 -> FIM_ERRO; else if contagem==DEPTH-1 -> FIM_ACERTO; else -> PROXIMO.
  - PROXIMO [6]: contaC=1. -> ESPERA.
  - FIM_ACERTO [10]: pronto=1, acertou=1. iniciar=1 -> PREPARA; else stay.
  - FIM_ERRO [14]: pronto=1, errou=1. iniciar=1 -> PREPARA; else stay.
  - Unused codes -> INICIAL.
- Outputs: pronto, acertou and errou are Moore outputs decoded from the state. acertou and errou are never high together.
- Latency: pulse seen in ESPERA at edge k -> REGISTRA after k, COMPARA after k+1, PROXIMO or FIM_* after k+2.
- iniciar outside INICIAL and FIM_* is ignored.
- Reset (asynchronous, any time, including mid-round):
  - state=INICIAL, contagem=0, register=0, jogada_d=0.
  - pronto=acertou=errou=0, db_estado=0, db_contagem=0, db_chaves=0, db_memoria=mem[0].

Test Plan (WIDTH=4, DEPTH=4 unless stated; mem = 3, 8, 13, 2):
- Reset pulse mid-clock -> all outputs at reset values immediately, before the next edge; db_estado=0; db_memoria=3.
- iniciar, then four moves with chaves=3, 8, 13, 2 (jogada high 3 cycles each) -> db_contagem steps 0..3. Two cycles after the fourth pulse's REGISTRA: pronto=1, acertou=1, errou=0, db_estado=10.
- Moves chaves=3 then chaves=9 -> FIM_ERRO with db_contagem=1, db_chaves=9, db_igual=0, errou=1, acertou=0.
- jogada held high 20 cycles in ESPERA with chaves=3 -> exactly one db_jogada pulse; db_contagem advances to 1 and no further.
- jogada pulses while in PREPARA or FIM_ACERTO -> ignored; db_contagem unchanged. iniciar in FIM_ERRO -> PREPARA -> ESPERA, with contagem=0 and db_chaves=0.
- WIDTH=6, DEPTH=10: correct sequence 3, 8, 13, ..., 48 -> acertou after 10 moves. Assert reset during position 5 -> state 0 and contagem 0 asynchronously.
